// File: rtl/reg_file_onehot.sv
// 32 x DATA_WIDTH register file written from a one-hot enable bus, with two combinational read ports.
// Reads are zero-cycle with same-cycle write-through bypass; writes commit on the rising clk edge.
module reg_file_onehot #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           en,
   input  logic [DATA_WIDTH-1:0] WD3,
   input  logic [4:0]            A1,
   input  logic [4:0]            A2,
   input  logic                  clear_err,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2,
   output logic                  err_multi,
   output logic [15:0]           write_count
);

   logic [DATA_WIDTH-1:0] regs_q [32];
   logic [DATA_WIDTH-1:0] regs_d [32];
   logic                  err_multi_q, err_multi_d;
   logic [15:0]           write_count_q, write_count_d;

   logic en_none, en_single, en_multi, wr_commit;

   // A vector is single-hot when clearing its lowest set bit leaves nothing behind.
   assign en_none   = (en == 32'd0);
   assign en_single = !en_none && ((en & (en - 32'd1)) == 32'd0);
   assign en_multi  = !en_none && !en_single;
   assign wr_commit = en_single && !en[0];

   always_comb begin
      regs_d        = regs_q;
      err_multi_d   = err_multi_q;
      write_count_d = write_count_q;
      for (int i = 1; i < 32; i++) begin
         if (en_single && en[i]) regs_d[i] = WD3;
      end
      if (en_multi)       err_multi_d = 1'b1;
      else if (clear_err) err_multi_d = 1'b0;
      if (wr_commit && (write_count_q != 16'hFFFF)) write_count_d = write_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         err_multi_q   <= 1'b0;
         write_count_q <= 16'd0;
      end else begin
         regs_q        <= regs_d;
         err_multi_q   <= err_multi_d;
         write_count_q <= write_count_d;
      end
   end

   // Reset forces both ports to zero immediately and disables the bypass.
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] a);
      logic [DATA_WIDTH-1:0] r;
      r = regs_q[a];
      if (reset || (a == 5'd0)) r = '0;
      else if (en_single && en[a]) r = WD3;
      return r;
   endfunction

   always_comb begin
      RD1 = read_port(A1);
      RD2 = read_port(A2);
   end

   assign err_multi   = err_multi_q;
   assign write_count = write_count_q;

   always_ff @(posedge clk) begin
      if (!reset) assert (!$isunknown(en));
   end

endmodule

// File: tb/tb_reg_file_onehot.sv
// Directed plus randomized checks of reg_file_onehot against an array-based reference model.
module tb_reg_file_onehot;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] en;
   logic [31:0] WD3;
   logic [4:0]  A1, A2;
   logic        clear_err;
   logic [31:0] RD1, RD2;
   logic        err_multi;
   logic [15:0] write_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   logic        m_err;
   int          m_cnt;

   reg_file_onehot #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .en(en), .WD3(WD3), .A1(A1), .A2(A2),
      .clear_err(clear_err), .RD1(RD1), .RD2(RD2),
      .err_multi(err_multi), .write_count(write_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a, input logic [31:0] e, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if ($countones(e) == 1 && e[a]) return wd;
      return m_regs[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   task automatic m_edge(input logic [31:0] e, input logic [31:0] wd, input logic clr);
      if ($countones(e) == 1) begin
         for (int k = 1; k < 32; k++) begin
            if (e == (32'd1 << k)) begin
               m_regs[k] = wd;
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
      if ($countones(e) > 1) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
   endtask

   // Called near the falling edge: applies inputs, checks reads pre-edge, clocks, checks state post-edge.
   task automatic cyc(input logic [31:0] e, input logic [31:0] wd, input logic [4:0] a1,
                      input logic [4:0] a2, input logic clr, input bit chk);
      en = e; WD3 = wd; A1 = a1; A2 = a2; clear_err = clr;
      #1;
      if (chk) begin
         check("rd1_pre", RD1, m_read(a1, e, wd));
         check("rd2_pre", RD2, m_read(a2, e, wd));
      end
      @(posedge clk);
      m_edge(e, wd, clr);
      #1;
      if (chk) begin
         check("err_multi", {31'd0, err_multi}, {31'd0, m_err});
         check("write_count", {16'd0, write_count}, m_cnt);
         check("rd1_post", RD1, m_read(a1, e, wd));
         check("rd2_post", RD2, m_read(a2, e, wd));
      end
      @(negedge clk);
   endtask

   task automatic readback_all();
      for (int i = 0; i < 32; i++) cyc(32'd0, $urandom, i[4:0], 5'(31 - i), 1'b0, 1'b1);
   endtask

   initial begin
      logic [31:0] e;
      int          r;
      m_reset();
      reset = 1'b1; en = 32'd0; WD3 = 32'd0; A1 = 5'd0; A2 = 5'd0; clear_err = 1'b0;

      // Reset held: outputs zero, bypass disabled even with a matching single-hot enable.
      #7;
      en = 32'd1 << 3; WD3 = 32'hCAFE_F00D; A1 = 5'd3; A2 = 5'd9;
      #1;
      check("reset_rd1", RD1, 32'd0);
      check("reset_rd2", RD2, 32'd0);
      check("reset_err", {31'd0, err_multi}, 32'd0);
      check("reset_cnt", {16'd0, write_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Walk every one-hot position, then read everything back.
      for (int i = 0; i < 32; i++) cyc(32'd1 << i, 32'hA5A5_0000 + i, i[4:0], i[4:0], 1'b0, 1'b1);
      check("walk_count", {16'd0, write_count}, 32'd31);
      readback_all();

      // Bypass: overwrite reg5 while reading it and neighbour reg6.
      cyc(32'd1 << 5, 32'h1111_1111, 5'd5, 5'd6, 1'b0, 1'b1);
      cyc(32'd1 << 5, 32'h2222_2222, 5'd5, 5'd6, 1'b0, 1'b1);
      check("bypass_rd1", RD1, 32'h2222_2222);
      cyc(32'd0, 32'h0, 5'd5, 5'd6, 1'b0, 1'b1);
      check("stored_rd1", RD1, 32'h2222_2222);

      // Multi-hot: no partial writes, error set, then cleared.
      cyc(32'h0000_0018, 32'hDEAD_BEEF, 5'd3, 5'd4, 1'b0, 1'b1);
      check("multi_err", {31'd0, err_multi}, 32'd1);
      check("multi_reg3", RD1, 32'hA5A5_0003);
      cyc(32'd0, 32'h0, 5'd3, 5'd4, 1'b1, 1'b1);
      check("clear_err", {31'd0, err_multi}, 32'd0);

      // Set beats clear on the same edge.
      cyc(32'h0000_0006, 32'h1234_5678, 5'd1, 5'd2, 1'b1, 1'b1);
      check("set_beats_clear", {31'd0, err_multi}, 32'd1);

      // Randomized traffic: idle, single-hot (including x0) and multi-hot enables.
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      e = 32'd0;
         else if (r < 8)  e = 32'd1 << $urandom_range(0, 31);
         else begin
            e = $urandom;
            if ($countones(e) < 2) e = e | 32'h8000_0001;
         end
         cyc(e, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 5) == 0), 1'b1);
      end
      cyc(32'h0000_0300, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);

      // Asynchronous reset pulse between edges.
      cyc(32'd1 << 7, 32'h7777_7777, 5'd7, 5'd8, 1'b0, 1'b1);
      cyc(32'd1 << 8, 32'h8888_8888, 5'd7, 5'd8, 1'b0, 1'b1);
      en = 32'd0; A1 = 5'd7; A2 = 5'd8;
      #1 reset = 1'b1;
      #1;
      check("async_rd1", RD1, 32'd0);
      check("async_rd2", RD2, 32'd0);
      check("async_err", {31'd0, err_multi}, 32'd0);
      check("async_cnt", {16'd0, write_count}, 32'd0);
      #2 reset = 1'b0;
      m_reset();
      @(negedge clk);
      readback_all();

      // Saturation of the write counter.
      for (int n = 0; n < 65540; n++) cyc(32'd2, 32'h5000_0000 + n, 5'd1, 5'd0, 1'b0, 1'b0);
      check("sat_count", {16'd0, write_count}, 32'h0000_FFFF);
      check("sat_model", {16'd0, write_count}, m_cnt);
      cyc(32'd0, 32'h0, 5'd1, 5'd1, 1'b0, 1'b1);
      check("sat_reg1", RD1, 32'h5000_0000 + 65539);
      cyc(32'd1 << 9, 32'h9999_9999, 5'd9, 5'd1, 1'b0, 1'b1);
      check("sat_hold", {16'd0, write_count}, 32'h0000_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
